modexp_param: RTL and testbench

Parametrised, handshaked modular exponentiator computing result = base^exp mod modulus for the Diffie-Hellman datapath. Uses right-to-left square-and-multiply over a serial interleaved modular multiplier. It has explicit busy/done/err signalling, operand width and exponent width as parameters, early termination on the exponent's top set bit, and base pre-reduction, so base may be greater than or equal to modulus.

---
 rtl/dh_pkg.sv | 16 +
 rtl/modmul_serial.sv | 80 ++++++++
 rtl/modexp_param.sv | 172 +++++++++++++++++
 tb/tb_modexp_param.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/dh_pkg.sv
// Shared definitions for the Diffie-Hellman modular exponentiation datapath.
// Holds the sequencer state encoding and the default operand widths.
package dh_pkg;

    localparam int DH_W  = 100;
    localparam int DH_EW = 101;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_REDUCE = 3'd1,
        S_MUL    = 3'd2,
        S_SQR    = 3'd3,
        S_DONE   = 3'd4
    } state_t;

endpackage

// File: rtl/modmul_serial.sv
// Bit-serial interleaved modular multiplier, p = a*b mod m with b < m.
// Consumes a MSB first; the first bit is folded into the accept edge.
module modmul_serial #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         go,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] m,
    output logic [W-1:0] p,
    output logic         rdy
);

    localparam int CW = $clog2(W + 1);

    logic [W-1:0]  r_a;
    logic [W-1:0]  r_b;
    logic [W-1:0]  r_m;
    logic [W-1:0]  r_acc;
    logic [CW-1:0] r_cnt;
    logic          r_run;
    logic          r_rdy;

    // acc < m keeps every intermediate below 2m, so W+1 bits suffice.
    function automatic logic [W-1:0] f_step(
        input logic [W-1:0] acc,
        input logic         bit_i,
        input logic [W-1:0] bb,
        input logic [W-1:0] mm
    );
        logic [W:0] t;
        t = {acc, 1'b0};
        if (t >= {1'b0, mm}) begin
            t = t - {1'b0, mm};
        end
        if (bit_i) begin
            t = t + {1'b0, bb};
            if (t >= {1'b0, mm}) begin
                t = t - {1'b0, mm};
            end
        end
        return t[W-1:0];
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_a   <= '0;
            r_b   <= '0;
            r_m   <= '0;
            r_acc <= '0;
            r_cnt <= '0;
            r_run <= 1'b0;
            r_rdy <= 1'b0;
        end else begin
            r_rdy <= 1'b0;
            if (r_run) begin
                r_acc <= f_step(r_acc, r_a[W-1], r_b, r_m);
                r_a   <= r_a << 1;
                r_cnt <= r_cnt - CW'(1);
                if (r_cnt == CW'(1)) begin
                    r_run <= 1'b0;
                    r_rdy <= 1'b1;
                end
            end else if (go) begin
                r_a   <= a << 1;
                r_b   <= b;
                r_m   <= m;
                r_acc <= f_step('0, a[W-1], b, m);
                r_cnt <= CW'(W - 1);
                r_run <= 1'b1;
            end
        end
    end

    assign p   = r_acc;
    assign rdy = r_rdy;

endmodule

// File: rtl/modexp_param.sv
// Handshaked right-to-left square-and-multiply modular exponentiator.
// One serial multiplier is shared by the REDUCE, MUL and SQR steps.
module modexp_param
    import dh_pkg::*;
#(
    parameter int W  = DH_W,
    parameter int EW = DH_EW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [W-1:0]  base,
    input  logic [EW-1:0] exp_in,
    input  logic [W-1:0]  prime,
    output logic [W-1:0]  result,
    output logic          busy,
    output logic          done,
    output logic          err
);

    state_t        r_state;
    logic [W-1:0]  r_base;
    logic [W-1:0]  r_m;
    logic [W-1:0]  r_pow;
    logic [W-1:0]  r_acc;
    logic [EW-1:0] r_e;
    logic          r_go;
    logic [W-1:0]  r_result;
    logic          r_busy;
    logic          r_done;
    logic          r_err;

    logic [W-1:0]  w_a;
    logic [W-1:0]  w_b;
    logic [W-1:0]  w_p;
    logic          w_rdy;
    logic          w_m_small;
    logic          w_e_nz;
    logic          w_e_sh_nz;

    assign w_m_small = ~|prime[W-1:1];
    assign w_e_nz    = |r_e;
    assign w_e_sh_nz = |r_e[EW-1:1];

    always_comb begin
        w_a = r_base;
        w_b = W'(1);
        case (r_state)
            S_MUL: begin
                w_a = r_acc;
                w_b = r_pow;
            end
            S_SQR: begin
                w_a = r_pow;
                w_b = r_pow;
            end
            default: ;
        endcase
    end

    modmul_serial #(
        .W(W)
    ) u_mul (
        .clk (clk),
        .rst (rst),
        .go  (r_go),
        .a   (w_a),
        .b   (w_b),
        .m   (r_m),
        .p   (w_p),
        .rdy (w_rdy)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= S_IDLE;
            r_base   <= '0;
            r_m      <= '0;
            r_pow    <= '0;
            r_acc    <= '0;
            r_e      <= '0;
            r_go     <= 1'b0;
            r_result <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_go   <= 1'b0;
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_base <= base;
                        r_e    <= exp_in;
                        r_m    <= prime;
                        r_err  <= 1'b0;
                        if (w_m_small) begin
                            r_state  <= S_DONE;
                            r_done   <= 1'b1;
                            r_result <= '0;
                            r_err    <= (prime == '0);
                        end else begin
                            r_state <= S_REDUCE;
                            r_go    <= 1'b1;
                            r_busy  <= 1'b1;
                        end
                    end
                end
                S_REDUCE: begin
                    if (w_rdy) begin
                        r_pow <= w_p;
                        r_acc <= W'(1);
                        if (!w_e_nz) begin
                            r_state  <= S_DONE;
                            r_done   <= 1'b1;
                            r_busy   <= 1'b0;
                            r_result <= W'(1);
                        end else if (r_e[0]) begin
                            r_state <= S_MUL;
                            r_go    <= 1'b1;
                        end else begin
                            r_e     <= r_e >> 1;
                            r_state <= S_SQR;
                            r_go    <= 1'b1;
                        end
                    end
                end
                S_MUL: begin
                    if (w_rdy) begin
                        r_acc <= w_p;
                        // Early exit once the last set exponent bit is consumed.
                        if (!w_e_sh_nz) begin
                            r_state  <= S_DONE;
                            r_done   <= 1'b1;
                            r_busy   <= 1'b0;
                            r_result <= w_p;
                        end else begin
                            r_e     <= r_e >> 1;
                            r_state <= S_SQR;
                            r_go    <= 1'b1;
                        end
                    end
                end
                S_SQR: begin
                    if (w_rdy) begin
                        r_pow <= w_p;
                        if (r_e[0]) begin
                            r_state <= S_MUL;
                            r_go    <= 1'b1;
                        end else begin
                            r_e     <= r_e >> 1;
                            r_state <= S_SQR;
                            r_go    <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign result = r_result;
    assign busy   = r_busy;
    assign done   = r_done;
    assign err    = r_err;

endmodule

// File: tb/tb_modexp_param.sv
// Scoreboard bench for modexp_param at W=8, EW=9 with hand-computed vectors.
// Latency = edges from the accepting edge to the first edge sampling done=1.
module tb_modexp_param;

    localparam int W  = 8;
    localparam int EW = 9;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [W-1:0]  base;
    logic [EW-1:0] exp_in;
    logic [W-1:0]  prime;
    logic [W-1:0]  result;
    logic          busy;
    logic          done;
    logic          err;

    typedef struct {
        logic [W-1:0] res;
        logic         er;
        int           lat;
        int           t0;
    } exp_t;

    exp_t q[$];
    int   cyc      = 0;
    int   tests    = 0;
    int   fails    = 0;
    int   done_cnt = 0;
    int   busy_cnt = 0;

    modexp_param #(
        .W  (W),
        .EW (EW)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .base   (base),
        .exp_in (exp_in),
        .prime  (prime),
        .result (result),
        .busy   (busy),
        .done   (done),
        .err    (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint req);
        tests++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: pops one expectation per done pulse.
    initial begin
        exp_t it;
        logic prev_done;
        prev_done = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                busy_cnt  = 0;
                prev_done = 1'b0;
            end else begin
                if (busy) busy_cnt++;
                if (done) begin
                    done_cnt++;
                    if (q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL unexpected_done: result %0d err %0d with nothing pending",
                                 result, err);
                    end else begin
                        it = q.pop_front();
                        chk("result", result, it.res);
                        chk("err", err, it.er);
                        chk("latency", cyc - it.t0, it.lat);
                        chk("busy_cycles", busy_cnt, it.lat - 1);
                        chk("busy_at_done", busy, 0);
                        chk("done_single_pulse", prev_done, 0);
                    end
                    busy_cnt = 0;
                end
                prev_done = done;
            end
        end
    end

    task automatic run(input logic [W-1:0] b, input logic [EW-1:0] e,
                       input logic [W-1:0] p, input logic [W-1:0] res,
                       input logic er, input int lat, input bit inject);
        int d0;
        @(negedge clk);
        base   = b;
        exp_in = e;
        prime  = p;
        start  = 1'b1;
        d0     = done_cnt;
        q.push_back('{res, er, lat, cyc});
        @(negedge clk);
        start  = 1'b0;
        base   = 8'hA5;
        exp_in = 9'h1FF;
        prime  = 8'h00;
        chk("busy_after_accept", busy, (lat > 1) ? 1 : 0);
        if (lat > 1) chk("err_after_accept", err, 0);
        if (inject) begin
            repeat (5) @(negedge clk);
            base   = 8'd7;
            exp_in = 9'd3;
            prime  = 8'd11;
            start  = 1'b1;
            @(negedge clk);
            start  = 1'b0;
        end
        for (int i = 0; i < lat + 20 && done_cnt == d0; i++) @(negedge clk);
        if (done_cnt == d0) begin
            tests++;
            fails++;
            $display("FAIL done_timeout: no done within %0d cycles, expected %0d", lat + 20, lat);
            if (q.size() > 0) void'(q.pop_back());
        end
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int d0;
        rst    = 1'b0;
        start  = 1'b0;
        base   = '0;
        exp_in = '0;
        prime  = '0;
        repeat (3) @(negedge clk);
        chk("reset_result", result, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_err", err, 0);
        rst = 1'b1;
        @(negedge clk);

        // base, exp, prime, result, err, latency = N*(W+1)+1
        run(8'd5,   9'd23,  8'd23,  8'd5,   1'b0, 82,  0);
        run(8'd4,   9'd13,  8'd200, 8'd64,  1'b0, 64,  0);
        run(8'd250, 9'd1,   8'd23,  8'd20,  1'b0, 19,  0);
        run(8'd77,  9'd0,   8'd23,  8'd1,   1'b0, 10,  0);
        run(8'd9,   9'd5,   8'd1,   8'd0,   1'b0, 1,   0);
        run(8'd9,   9'd5,   8'd0,   8'd0,   1'b1, 1,   0);
        run(8'd2,   9'd8,   8'd251, 8'd5,   1'b0, 46,  0);
        run(8'd200, 9'd2,   8'd255, 8'd220, 1'b0, 28,  0);
        run(8'd3,   9'd511, 8'd2,   8'd1,   1'b0, 163, 0);
        run(8'd0,   9'd5,   8'd7,   8'd0,   1'b0, 46,  0);
        run(8'd5,   9'd23,  8'd23,  8'd5,   1'b0, 82,  1);

        // Abort a run with reset; nothing may complete afterwards.
        run(8'd4,   9'd13,  8'd200, 8'd64,  1'b0, 64,  0);
        @(negedge clk);
        base   = 8'd5;
        exp_in = 9'd23;
        prime  = 8'd23;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (30) @(negedge clk);
        d0  = done_cnt;
        rst = 1'b0;
        @(negedge clk);
        chk("midreset_result", result, 0);
        chk("midreset_busy", busy, 0);
        chk("midreset_done", done, 0);
        chk("midreset_err", err, 0);
        @(negedge clk);
        rst = 1'b1;
        repeat (120) @(negedge clk);
        chk("no_done_after_reset", done_cnt - d0, 0);
        chk("idle_busy_after_reset", busy, 0);
        run(8'd5,   9'd23,  8'd23,  8'd5,   1'b0, 82,  0);

        repeat (5) @(negedge clk);
        chk("scoreboard_drained", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
